execute_operand_bypass: RTL

Consumer end of the execute-stage forwarding path. Resolves the GR, SPR and FRCR source operands of the instruction entering execute, choosing between the current writeback result, the forwarding registers and register-file read data. Holds a 32-entry scoreboard of long-latency GR writes and stalls on unresolved hazards. Sits between the decode/issue register and the execute ALU, with a one-entry registered output stage and a valid/busy handshake.

---
 rtl/execute_bypass_pkg.sv | 14 +
 rtl/execute_bypass_select.sv | 26 ++
 rtl/execute_operand_bypass.sv | 117 +++++++++++
 3 files changed

// File: rtl/execute_bypass_pkg.sv
// execute_bypass_pkg: shared types and sizing for the execute-stage operand bypass.
package execute_bypass_pkg;
  localparam int GR_AW = 5;
  typedef enum logic [1:0] {SEL_WB, SEL_FDR, SEL_RF} src_sel_e;
  typedef struct packed {
    logic [31:0] src0;
    logic [31:0] src1;
    logic [31:0] spr;
    logic [63:0] frcr;
  } bypass_data_t;
  function automatic int sb_depth(input int aw);
    return 2 ** aw;
  endfunction
endpackage

// File: rtl/execute_bypass_select.sv
// execute_bypass_select: writeback > forwarding register > register file priority mux for one GR source.
module execute_bypass_select import execute_bypass_pkg::*; #(
  parameter int P_GR_AW = GR_AW
) (
  input  logic [P_GR_AW-1:0] addr,
  input  logic               sysreg,
  input  logic [31:0]        rf_data,
  input  logic               wb_valid,
  input  logic [P_GR_AW-1:0] wb_dest,
  input  logic               wb_sysreg,
  input  logic [31:0]        wb_data,
  input  logic               fdr_valid,
  input  logic [P_GR_AW-1:0] fdr_dest,
  input  logic               fdr_sysreg,
  input  logic [31:0]        fdr_data,
  output logic [31:0]        data
);
  src_sel_e sel;
  logic wb_hit, fdr_hit;
  always_comb begin
    wb_hit  = wb_valid && wb_dest == addr && wb_sysreg == sysreg;
    fdr_hit = fdr_valid && fdr_dest == addr && fdr_sysreg == sysreg;
    sel     = wb_hit ? SEL_WB : fdr_hit ? SEL_FDR : SEL_RF;
    data    = sel == SEL_WB ? wb_data : sel == SEL_FDR ? fdr_data : rf_data;
  end
endmodule

// File: rtl/execute_operand_bypass.sv
// execute_operand_bypass: resolves execute operands, tracks long-latency GR writes and
// stalls issue on unresolved hazards, with a one-entry registered output stage.
module execute_operand_bypass import execute_bypass_pkg::*; #(
  parameter int P_GR_AW = GR_AW
) (
  input  logic               iCLOCK,
  input  logic               inRESET,
  input  logic               iRESET_SYNC,
  input  logic               iEVENT_FLUSH,
  input  logic               iPREV_VALID,
  output logic               oPREV_BUSY,
  input  logic               iPREV_SRC0_USE,
  input  logic               iPREV_SRC1_USE,
  input  logic [P_GR_AW-1:0] iPREV_SRC0_ADDR,
  input  logic [P_GR_AW-1:0] iPREV_SRC1_ADDR,
  input  logic               iPREV_SRC0_SYSREG,
  input  logic               iPREV_SPR_USE,
  input  logic               iPREV_FRCR_USE,
  input  logic [P_GR_AW-1:0] iPREV_DEST_ADDR,
  input  logic               iPREV_DEST_SYSREG,
  input  logic               iPREV_DEST_LONG,
  input  logic [31:0]        iRF_SRC0_DATA,
  input  logic [31:0]        iRF_SRC1_DATA,
  input  logic               iWB_GR_VALID,
  input  logic [31:0]        iWB_GR_DATA,
  input  logic [P_GR_AW-1:0] iWB_GR_DEST,
  input  logic               iWB_GR_DEST_SYSREG,
  input  logic               iFDR_GR_VALID,
  input  logic [31:0]        iFDR_GR_DATA,
  input  logic [P_GR_AW-1:0] iFDR_GR_DEST,
  input  logic               iFDR_GR_DEST_SYSREG,
  input  logic               iFDR_SPR_VALID,
  input  logic [31:0]        iFDR_SPR_DATA,
  input  logic               iFDR_FRCR_VALID,
  input  logic [63:0]        iFDR_FRCR_DATA,
  output logic               oNEXT_VALID,
  input  logic               iNEXT_BUSY,
  output logic [31:0]        oNEXT_SRC0,
  output logic [31:0]        oNEXT_SRC1,
  output logic [31:0]        oNEXT_SPR,
  output logic [63:0]        oNEXT_FRCR,
  output logic [P_GR_AW-1:0] oNEXT_DEST,
  output logic               oNEXT_DEST_SYSREG,
  output logic [P_GR_AW:0]   oSB_COUNT,
  output logic               oSTALL_HAZARD
);
  localparam int SB_D = sb_depth(P_GR_AW);
  localparam logic [SB_D-1:0] ONE = {{(SB_D-1){1'b0}}, 1'b1};
  logic [SB_D-1:0] sb, sb_n, set_m, clr_m;
  logic [P_GR_AW:0] cnt_n;
  logic run, wb_clr, pend0, pend1, accept;
  bypass_data_t q, d;
  execute_bypass_select #(.P_GR_AW(P_GR_AW)) u_sel0 (
    .addr(iPREV_SRC0_ADDR), .sysreg(iPREV_SRC0_SYSREG), .rf_data(iRF_SRC0_DATA),
    .wb_valid(iWB_GR_VALID), .wb_dest(iWB_GR_DEST), .wb_sysreg(iWB_GR_DEST_SYSREG), .wb_data(iWB_GR_DATA),
    .fdr_valid(iFDR_GR_VALID), .fdr_dest(iFDR_GR_DEST), .fdr_sysreg(iFDR_GR_DEST_SYSREG), .fdr_data(iFDR_GR_DATA),
    .data(d.src0)
  );
  execute_bypass_select #(.P_GR_AW(P_GR_AW)) u_sel1 (
    .addr(iPREV_SRC1_ADDR), .sysreg(1'b0), .rf_data(iRF_SRC1_DATA),
    .wb_valid(iWB_GR_VALID), .wb_dest(iWB_GR_DEST), .wb_sysreg(iWB_GR_DEST_SYSREG), .wb_data(iWB_GR_DATA),
    .fdr_valid(iFDR_GR_VALID), .fdr_dest(iFDR_GR_DEST), .fdr_sysreg(iFDR_GR_DEST_SYSREG), .fdr_data(iFDR_GR_DATA),
    .data(d.src1)
  );
  assign d.spr  = iFDR_SPR_DATA;
  assign d.frcr = iFDR_FRCR_DATA;
  // Handshake outputs are forced low while either reset is active.
  assign run    = inRESET & ~iRESET_SYNC;
  assign wb_clr = iWB_GR_VALID & ~iWB_GR_DEST_SYSREG;
  assign pend0  = iPREV_SRC0_USE & ~iPREV_SRC0_SYSREG & sb[iPREV_SRC0_ADDR] &
                  ~(wb_clr & (iWB_GR_DEST == iPREV_SRC0_ADDR));
  assign pend1  = iPREV_SRC1_USE & sb[iPREV_SRC1_ADDR] &
                  ~(wb_clr & (iWB_GR_DEST == iPREV_SRC1_ADDR));
  assign oSTALL_HAZARD = run & iPREV_VALID & (pend0 | pend1 | (iPREV_SPR_USE & ~iFDR_SPR_VALID) |
                         (iPREV_FRCR_USE & ~iFDR_FRCR_VALID));
  assign oPREV_BUSY = run & (oSTALL_HAZARD | (oNEXT_VALID & iNEXT_BUSY));
  assign accept     = iPREV_VALID & ~oPREV_BUSY & ~iEVENT_FLUSH;
  // Set is applied after clear so a same-cycle set wins.
  always_comb begin
    clr_m = wb_clr ? ONE << iWB_GR_DEST : '0;
    set_m = (accept & iPREV_DEST_LONG & ~iPREV_DEST_SYSREG) ? ONE << iPREV_DEST_ADDR : '0;
    sb_n  = iEVENT_FLUSH ? '0 : (sb & ~clr_m) | set_m;
    cnt_n = '0;
    for (int i = 0; i < SB_D; i++) cnt_n = cnt_n + (P_GR_AW + 1)'(sb_n[i]);
  end
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      sb <= '0;
      oSB_COUNT <= '0;
      oNEXT_VALID <= 1'b0;
      q <= '0;
      oNEXT_DEST <= '0;
      oNEXT_DEST_SYSREG <= 1'b0;
    end else if (iRESET_SYNC) begin
      sb <= '0;
      oSB_COUNT <= '0;
      oNEXT_VALID <= 1'b0;
      q <= '0;
      oNEXT_DEST <= '0;
      oNEXT_DEST_SYSREG <= 1'b0;
    end else begin
      sb <= sb_n;
      oSB_COUNT <= cnt_n;
      if (iEVENT_FLUSH) oNEXT_VALID <= 1'b0;
      else if (accept) begin
        oNEXT_VALID <= 1'b1;
        q <= d;
        oNEXT_DEST <= iPREV_DEST_ADDR;
        oNEXT_DEST_SYSREG <= iPREV_DEST_SYSREG;
      end else if (!iNEXT_BUSY) oNEXT_VALID <= 1'b0;
    end
  end
  assign oNEXT_SRC0 = q.src0;
  assign oNEXT_SRC1 = q.src1;
  assign oNEXT_SPR  = q.spr;
  assign oNEXT_FRCR = q.frcr;
endmodule
